// File: rtl/udp2eth_pkg.sv
// Shared definitions for the UDP receive path: header geometry, fixed field
// values and the framer/deframer state encoding.
package udp2eth_pkg;

  localparam int HWIDTHB = 42;                 // Eth(14) + IPv4(20) + UDP(8)
  localparam int SWIDTHB = 64;
  localparam int RWIDTHB = SWIDTHB - HWIDTHB;  // payload bytes sharing beat 0

  localparam int OFF_ETH_TYPE  = 12;
  localparam int OFF_VER_IHL   = 14;
  localparam int OFF_IP_PROTO  = 23;
  localparam int OFF_UDP_DPORT = 36;
  localparam int OFF_UDP_LEN   = 38;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BODY  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } udp_state_t;

  // Network-order 16-bit field starting at byte 'off' of the header.
  function automatic logic [15:0] be16(input logic [HWIDTHB*8-1:0] hdr, input int off);
    return {hdr[8*off +: 8], hdr[8*(off+1) +: 8]};
  endfunction

endpackage

// File: rtl/udp_hdr_check.sv
// Combinational Eth/IPv4/UDP header filter: extracts the fixed fields from the
// first 42 bytes of a frame and decides whether the frame is ours.
module udp_hdr_check
  import udp2eth_pkg::*;
#(
  parameter int unsigned DST_PORT = 32000,
  parameter int          CHECK_IP = 1
) (
  input  logic [HWIDTHB*8-1:0] hdr,
  input  logic                 hdr_keep,
  output logic                 accept,
  output logic [15:0]          udp_len
);

  logic [15:0] eth_type;
  logic [15:0] dst_port;
  logic [7:0]  ver_ihl;
  logic [7:0]  ip_proto;
  logic        eth_ok;
  logic        ip_ok;
  logic        port_ok;
  logic        len_ok;
  logic        unused_hdr;

  assign eth_type = be16(hdr, OFF_ETH_TYPE);
  assign dst_port = be16(hdr, OFF_UDP_DPORT);
  assign udp_len  = be16(hdr, OFF_UDP_LEN);
  assign ver_ihl  = hdr[8*OFF_VER_IHL +: 8];
  assign ip_proto = hdr[8*OFF_IP_PROTO +: 8];

  assign eth_ok  = (eth_type == ETH_TYPE_IPV4);
  assign ip_ok   = (CHECK_IP == 0) || ((ver_ihl == IP_VER_IHL) && (ip_proto == IP_PROTO_UDP));
  assign port_ok = (DST_PORT == 0) || (dst_port == 16'(DST_PORT));
  assign len_ok  = (udp_len >= UDP_HDR_LEN);

  // hdr_keep is the enable of the last header byte: a short frame never matches.
  assign accept = eth_ok & ip_ok & port_ok & len_ok & hdr_keep;

  // MAC addresses, checksums and the remaining IP fields are not inspected.
  assign unused_hdr = ^hdr;

endmodule

// File: rtl/udp2eth.sv
// UDP receive deframer: filters Eth/IPv4/UDP frames, strips the 42-byte header,
// re-aligns the payload to byte 0 and reports the payload length separately.
module udp2eth
  import udp2eth_pkg::*;
#(
  parameter int          SWIDTH   = 512,  // fixed: 64-byte beats
  parameter int unsigned DST_PORT = 32000,
  parameter int          CHECK_IP = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [SWIDTH-1:0]   AXIS_RX_TDATA,
  input  logic [SWIDTH/8-1:0] AXIS_RX_TKEEP,
  input  logic                AXIS_RX_TVALID,
  input  logic                AXIS_RX_TLAST,
  output logic                AXIS_RX_TREADY,
  output logic [SWIDTH-1:0]   AXIS_TX_TDATA,
  output logic [SWIDTH/8-1:0] AXIS_TX_TKEEP,
  output logic                AXIS_TX_TVALID,
  output logic                AXIS_TX_TLAST,
  input  logic                AXIS_TX_TREADY,
  output logic [15:0]         AXIS_LEN_TDATA,
  output logic                AXIS_LEN_TVALID,
  input  logic                AXIS_LEN_TREADY,
  output logic [31:0]         DROP_COUNT,
  output logic [31:0]         PKT_COUNT,
  output logic [1:0]          dbg_state
);

  // All three streams: a beat transfers on the rising edge where VALID and
  // READY are both high; VALID never depends on READY and holds until taken.

  localparam int HB = HWIDTHB * 8;
  localparam int RB = SWIDTH - HB;
  localparam int KB = SWIDTH / 8;

  udp_state_t      state_q;
  udp_state_t      state_d;
  logic [RB-1:0]   hold_q;
  logic [RWIDTHB-1:0] hold_keep_q;
  logic            len_valid_q;
  logic [15:0]     len_q;
  logic [31:0]     pkt_q;
  logic [31:0]     drop_q;
  logic            run_q;

  logic            rx_ready;
  logic            rx_hs;
  logic            tx_valid;
  logic            tx_last;
  logic [SWIDTH-1:0] tx_data;
  logic [KB-1:0]   tx_keep;
  logic            hdr_accept;
  logic [15:0]     udp_len;

  udp_hdr_check #(
    .DST_PORT (DST_PORT),
    .CHECK_IP (CHECK_IP)
  ) u_hdr_check (
    .hdr      (AXIS_RX_TDATA[HB-1:0]),
    .hdr_keep (AXIS_RX_TKEEP[HWIDTHB-1]),
    .accept   (hdr_accept),
    .udp_len  (udp_len)
  );

  assign rx_hs = AXIS_RX_TVALID & rx_ready;

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    tx_keep  = '0;
    case (state_q)
      ST_IDLE: begin
        // run_q keeps the input closed until the first edge after reset.
        rx_ready = run_q & ~len_valid_q;
        if (AXIS_RX_TVALID && rx_ready) begin
          if (hdr_accept) state_d = AXIS_RX_TLAST ? ST_FLUSH : ST_BODY;
          else            state_d = AXIS_RX_TLAST ? ST_IDLE  : ST_DROP;
        end
      end
      ST_BODY: begin
        tx_data  = {AXIS_RX_TDATA[HB-1:0], hold_q};
        tx_keep  = {AXIS_RX_TKEEP[HWIDTHB-1:0], hold_keep_q};
        tx_valid = AXIS_RX_TVALID;
        rx_ready = AXIS_TX_TREADY;
        // A last beat with bytes past offset 41 leaves a tail for FLUSH.
        tx_last  = AXIS_RX_TLAST & ~AXIS_RX_TKEEP[HWIDTHB];
        if (AXIS_RX_TVALID && rx_ready && AXIS_RX_TLAST)
          state_d = AXIS_RX_TKEEP[HWIDTHB] ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        tx_data  = {{HB{1'b0}}, hold_q};
        tx_keep  = {{HWIDTHB{1'b0}}, hold_keep_q};
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        if (AXIS_TX_TREADY) state_d = ST_IDLE;
      end
      ST_DROP: begin
        rx_ready = 1'b1;
        if (AXIS_RX_TVALID && AXIS_RX_TLAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q      <= '0;
      hold_keep_q <= '0;
      len_valid_q <= 1'b0;
      len_q       <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
    end else begin
      if (rx_hs && (state_q == ST_IDLE || state_q == ST_BODY)) begin
        hold_q      <= AXIS_RX_TDATA[SWIDTH-1:HB];
        hold_keep_q <= AXIS_RX_TKEEP[KB-1:HWIDTHB];
      end
      if (len_valid_q && AXIS_LEN_TREADY)
        len_valid_q <= 1'b0;
      // A header is only taken while no length is pending, so set and
      // clear of len_valid_q never coincide.
      if (rx_hs && state_q == ST_IDLE) begin
        if (hdr_accept) begin
          len_valid_q <= 1'b1;
          len_q       <= udp_len - UDP_HDR_LEN;
          pkt_q       <= pkt_q + 32'd1;
        end else begin
          drop_q      <= drop_q + 32'd1;
        end
      end
    end
  end

  assign AXIS_RX_TREADY  = rx_ready;
  assign AXIS_TX_TDATA   = tx_data;
  assign AXIS_TX_TKEEP   = tx_keep;
  assign AXIS_TX_TVALID  = tx_valid;
  assign AXIS_TX_TLAST   = tx_last;
  assign AXIS_LEN_TDATA  = len_q;
  assign AXIS_LEN_TVALID = len_valid_q;
  assign DROP_COUNT      = drop_q;
  assign PKT_COUNT       = pkt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_udp2eth.sv
// Bench for udp2eth: frames are built as byte arrays, a byte-level model turns
// each into expected payload beats and lengths, and a monitor checks every handshake.
module tb_udp2eth;

  localparam int SW  = 512;
  localparam int KW  = 64;
  localparam int DST = 32000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // ---------------- main DUT (DST_PORT=32000) ----------------
  logic [SW-1:0] rx_tdata;  logic [KW-1:0] rx_tkeep;
  logic rx_tvalid, rx_tlast, rx_tready;
  logic [SW-1:0] tx_tdata;  logic [KW-1:0] tx_tkeep;
  logic tx_tvalid, tx_tlast, tx_tready;
  logic [15:0] len_tdata;   logic len_tvalid, len_tready;
  logic [31:0] drop_count, pkt_count;
  logic [1:0]  dbg_state;

  udp2eth #(.SWIDTH(SW), .DST_PORT(DST), .CHECK_IP(1)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_RX_TDATA(rx_tdata), .AXIS_RX_TKEEP(rx_tkeep), .AXIS_RX_TVALID(rx_tvalid),
    .AXIS_RX_TLAST(rx_tlast), .AXIS_RX_TREADY(rx_tready),
    .AXIS_TX_TDATA(tx_tdata), .AXIS_TX_TKEEP(tx_tkeep), .AXIS_TX_TVALID(tx_tvalid),
    .AXIS_TX_TLAST(tx_tlast), .AXIS_TX_TREADY(tx_tready),
    .AXIS_LEN_TDATA(len_tdata), .AXIS_LEN_TVALID(len_tvalid), .AXIS_LEN_TREADY(len_tready),
    .DROP_COUNT(drop_count), .PKT_COUNT(pkt_count), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (DST_PORT=0, any port) ----------------
  logic [SW-1:0] a_rx_tdata;  logic [KW-1:0] a_rx_tkeep;
  logic a_rx_tvalid, a_rx_tlast, a_rx_tready;
  logic [SW-1:0] a_tx_tdata;  logic [KW-1:0] a_tx_tkeep;
  logic a_tx_tvalid, a_tx_tlast, a_tx_tready;
  logic [15:0] a_len_tdata;   logic a_len_tvalid, a_len_tready;
  logic [31:0] a_drop_count, a_pkt_count;
  logic [1:0]  a_dbg_state;

  udp2eth #(.SWIDTH(SW), .DST_PORT(0), .CHECK_IP(1)) dut_any (
    .clk(clk), .resetn(resetn),
    .AXIS_RX_TDATA(a_rx_tdata), .AXIS_RX_TKEEP(a_rx_tkeep), .AXIS_RX_TVALID(a_rx_tvalid),
    .AXIS_RX_TLAST(a_rx_tlast), .AXIS_RX_TREADY(a_rx_tready),
    .AXIS_TX_TDATA(a_tx_tdata), .AXIS_TX_TKEEP(a_tx_tkeep), .AXIS_TX_TVALID(a_tx_tvalid),
    .AXIS_TX_TLAST(a_tx_tlast), .AXIS_TX_TREADY(a_tx_tready),
    .AXIS_LEN_TDATA(a_len_tdata), .AXIS_LEN_TVALID(a_len_tvalid), .AXIS_LEN_TREADY(a_len_tready),
    .DROP_COUNT(a_drop_count), .PKT_COUNT(a_pkt_count), .dbg_state(a_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [SW-1:0] exp_data_q[$];
  logic [KW-1:0] exp_keep_q[$];
  logic          exp_last_q[$];
  logic [15:0]   exp_len_q[$];
  int exp_pkt  = 0;
  int exp_drop = 0;

  logic [7:0] frm [0:255];
  int frm_n;
  bit tx_rand = 1'b0;
  bit tx_hold = 1'b0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [SW-1:0] kmask(input logic [KW-1:0] k);
    logic [SW-1:0] m;
    m = '0;
    for (int j = 0; j < KW; j++) if (k[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- frame construction and model ----------------
  task automatic build_frame(input logic [15:0] etype, input logic [7:0] ver, input logic [7:0] proto,
                             input logic [15:0] port, input logic [15:0] udplen, input int pay_n);
    frm_n = 42 + pay_n;
    for (int i = 0; i < 256; i++) frm[i] = 8'($urandom_range(0, 255));
    frm[12] = etype[15:8];  frm[13] = etype[7:0];
    frm[14] = ver;          frm[23] = proto;
    frm[36] = port[15:8];   frm[37] = port[7:0];
    frm[38] = udplen[15:8]; frm[39] = udplen[7:0];
  endtask

  // Payload = frame bytes 42..n-1 cut into 64-byte output beats.
  task automatic model_frame();
    logic [15:0] et, pt, ul;
    bit ok;
    et = {frm[12], frm[13]};
    pt = {frm[36], frm[37]};
    ul = {frm[38], frm[39]};
    ok = (et == 16'h0800) && (frm[14] == 8'h45) && (frm[23] == 8'h11) &&
         (pt == 16'(DST)) && (ul >= 16'd8) && (frm_n >= 42);
    if (!ok) begin
      exp_drop++;
      return;
    end
    exp_pkt++;
    exp_len_q.push_back(ul - 16'd8);
    for (int s = 42; s < frm_n; s += 64) begin
      logic [SW-1:0] d;
      logic [KW-1:0] k;
      d = '0;
      k = '0;
      for (int j = 0; j < 64; j++)
        if (s + j < frm_n) begin
          d[8*j +: 8] = frm[s + j];
          k[j] = 1'b1;
        end
      exp_data_q.push_back(d);
      exp_keep_q.push_back(k);
      exp_last_q.push_back(s + 64 >= frm_n);
    end
  endtask

  task automatic pack_beat(input int b, output logic [SW-1:0] d, output logic [KW-1:0] k);
    d = '0;
    k = '0;
    for (int j = 0; j < 64; j++)
      if (b*64 + j < frm_n) begin
        d[8*j +: 8] = frm[b*64 + j];
        k[j] = 1'b1;
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [SW-1:0] d, input logic [KW-1:0] k, input logic last,
                            input bit chk_rdy);
    int cnt;
    rx_tdata = d; rx_tkeep = k; rx_tlast = last; rx_tvalid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      if (cnt == 0 && chk_rdy) check("drop_rx_ready", rx_tready, 1);
      cnt++;
    end while (!rx_tready && cnt < 300);
    if (!rx_tready) fail_now("rx_beat");
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, input bit chk_rdy);
    logic [SW-1:0] d;
    logic [KW-1:0] k;
    int nb;
    nb = (frm_n + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      pack_beat(b, d, k);
      drive_beat(d, k, b == nb - 1, chk_rdy);
    end
  endtask

  task automatic drain(input bit incl_len);
    int c;
    c = 0;
    while ((exp_data_q.size() != 0 || (incl_len && exp_len_q.size() != 0)) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 2000) fail_now("drain");
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pkt_count"}, pkt_count, exp_pkt);
    check({tag, "_drop_count"}, drop_count, exp_drop);
  endtask

  // ---------------- TX ready pattern ----------------
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_tready = tx_hold ? 1'b0 : (tx_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [SW-1:0] d;
    logic [KW-1:0] k;
    logic l;
    logic [15:0] ln;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (tx_tvalid && tx_tready) begin
          if (exp_data_q.size() == 0) begin
            fail_now("tx_unexpected_beat");
          end else begin
            d = exp_data_q.pop_front();
            k = exp_keep_q.pop_front();
            l = exp_last_q.pop_front();
            check("tx_keep", tx_tkeep, k);
            check("tx_data", tx_tdata & kmask(k), d);
            check("tx_last", tx_tlast, l);
          end
        end
        if (len_tvalid && len_tready) begin
          if (exp_len_q.size() == 0) begin
            fail_now("len_unexpected");
          end else begin
            ln = exp_len_q.pop_front();
            check("len_tdata", len_tdata, ln);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [SW-1:0] d, ed;
    logic [KW-1:0] k;
    int c;

    resetn = 1'b0;
    rx_tdata = '0; rx_tkeep = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0;
    len_tready = 1'b1;
    a_rx_tdata = '0; a_rx_tkeep = '0; a_rx_tvalid = 1'b0; a_rx_tlast = 1'b0;
    a_tx_tready = 1'b0; a_len_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", rx_tready, 0);
    check("rst_tx_valid", tx_tvalid, 0);
    check("rst_len_valid", len_tvalid, 0);
    check("rst_state", dbg_state, 0);
    check_counts("rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // 64-byte payload, two RX beats, one full TX beat
    build_frame(16'h0800, 8'h45, 8'h11, 16'd32000, 16'd72, 64);
    model_frame();
    check("t1_model_len", exp_len_q[$], 64);
    check("t1_model_beats", exp_data_q.size(), 1);
    check("t1_model_keep", exp_keep_q[$], {KW{1'b1}});
    send_frame(0, 1'b0);
    drain(1'b1);
    check_counts("t1");

    // 10-byte payload in one RX beat, emitted from FLUSH
    build_frame(16'h0800, 8'h45, 8'h11, 16'd32000, 16'd18, 10);
    model_frame();
    check("t2_model_keep", exp_keep_q[$], 64'h3FF);
    check("t2_model_len", exp_len_q[$], 10);
    send_frame(0, 1'b0);
    drain(1'b1);
    check_counts("t2");
    check("t2_pkt_literal", pkt_count, 2);

    // IPv6 ethertype, three beats, all swallowed
    build_frame(16'h86DD, 8'h60, 8'h11, 16'd32000, 16'd158, 150);
    model_frame();
    send_frame(0, 1'b0);
    @(posedge clk); #1;
    build_frame(16'h86DD, 8'h60, 8'h11, 16'd32000, 16'd158, 150);
    exp_drop = exp_drop;
    drain(1'b1);
    check_counts("t3");
    check("t3_drop_literal", drop_count, 1);

    // wrong port; DROP state must take every beat without stalling
    build_frame(16'h0800, 8'h45, 8'h11, 16'd1234, 16'd158, 150);
    model_frame();
    send_frame(0, 1'b1);
    drain(1'b1);
    check_counts("t4");
    check("t4_drop_literal", drop_count, 2);

    // random gaps with the length stream stalled
    tx_rand = 1'b1;
    len_tready = 1'b0;
    build_frame(16'h0800, 8'h45, 8'h11, 16'd32000, 16'd108, 100);
    model_frame();
    send_frame(3, 1'b0);
    drain(1'b0);
    build_frame(16'h0800, 8'h45, 8'h11, 16'd32000, 16'd58, 50);
    model_frame();
    fork
      send_frame(2, 1'b0);
      begin
        repeat (8) begin
          @(negedge clk);
          check("t5_hdr_blocked", rx_tready, 0);
          check("t5_len_pending", len_tvalid, 1);
        end
        @(posedge clk); #1;
        len_tready = 1'b1;
      end
    join
    drain(1'b1);
    build_frame(16'h0800, 8'h45, 8'h11, 16'd32000, 16'd80, 72);
    model_frame();
    check("t5_model_flush_keep", exp_keep_q[$], 64'hFF);
    send_frame(2, 1'b0);
    drain(1'b1);
    tx_rand = 1'b0;
    check_counts("t5");

    // reset in the middle of BODY
    tx_hold = 1'b1;
    len_tready = 1'b0;
    build_frame(16'h0800, 8'h45, 8'h11, 16'd32000, 16'd158, 150);
    model_frame();
    pack_beat(0, d, k);
    drive_beat(d, k, 1'b0, 1'b0);
    pack_beat(1, d, k);
    rx_tdata = d; rx_tkeep = k; rx_tlast = 1'b0; rx_tvalid = 1'b1;
    @(negedge clk);
    check("t6_body_tx_valid", tx_tvalid, 1);
    check("t6_body_len_valid", len_tvalid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_tx_valid", tx_tvalid, 0);
    check("t6_rst_len_valid", len_tvalid, 0);
    check("t6_rst_rx_ready", rx_tready, 0);
    check("t6_rst_pkt", pkt_count, 0);
    check("t6_rst_state", dbg_state, 0);
    exp_data_q.delete(); exp_keep_q.delete(); exp_last_q.delete(); exp_len_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    rx_tvalid = 1'b0;
    tx_hold = 1'b0;
    len_tready = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;
    build_frame(16'h0800, 8'h45, 8'h11, 16'd32000, 16'd18, 10);
    model_frame();
    send_frame(0, 1'b0);
    drain(1'b1);
    check("t6_pkt_literal", pkt_count, 1);
    check("t6_drop_literal", drop_count, 0);

    // port 1234 accepted by the any-port instance
    build_frame(16'h0800, 8'h45, 8'h11, 16'd1234, 16'd18, 10);
    pack_beat(0, d, k);
    ed = '0;
    for (int j = 0; j < 10; j++) ed[8*j +: 8] = frm[42 + j];
    a_rx_tdata = d; a_rx_tkeep = k; a_rx_tlast = 1'b1; a_rx_tvalid = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!a_rx_tready && c < 50);
    if (!a_rx_tready) fail_now("any_rx_beat");
    @(posedge clk); #1;
    a_rx_tvalid = 1'b0;
    @(negedge clk);
    check("any_tx_valid", a_tx_tvalid, 1);
    check("any_tx_keep", a_tx_tkeep, 64'h3FF);
    check("any_tx_last", a_tx_tlast, 1);
    check("any_tx_data", a_tx_tdata & kmask(64'h3FF), ed);
    check("any_len_valid", a_len_tvalid, 1);
    check("any_len", a_len_tdata, 10);
    a_tx_tready = 1'b1;
    a_len_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("any_tx_done", a_tx_tvalid, 0);
    check("any_len_done", a_len_tvalid, 0);
    check("any_pkt", a_pkt_count, 1);
    check("any_drop", a_drop_count, 0);

    // main instance must not have produced anything stray meanwhile
    check("final_exp_tx_empty", exp_data_q.size(), 0);
    check("final_exp_len_empty", exp_len_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
